// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - opcode constants, bubble word and IF/ID record shared by the fetch stage
package fetch_pkg;

    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        pred_taken;
    } ifid_t;

endpackage

// File: rtl/fetch_predecode.sv
// rtl/fetch_predecode.sv - static predictor: JAL and backward branches taken, else pc+4
module fetch_predecode
    import fetch_pkg::*;
#(
    parameter bit PREDICT_EN = 1'b1
) (
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic        pred_taken,
    output logic [31:0] pred_target
);

    logic [31:0] jal_off;
    logic [31:0] br_off;

    always_comb begin
        jal_off     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        br_off      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        pred_taken  = 1'b0;
        pred_target = pc + 32'd4;
        if (PREDICT_EN) begin
            if (instr[6:0] == OPC_JAL) begin
                pred_taken  = 1'b1;
                pred_target = pc + jal_off;
            end else if (instr[6:0] == OPC_BRANCH && instr[31]) begin
                // sign bit set means a backward offset; JALR is left for decode
                pred_taken  = 1'b1;
                pred_target = pc + br_off;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, static-predicted next PC, IF/ID register and redirect counter
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = NOP_WORD,
    parameter bit          PREDICT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        npc_control,
    input  logic [31:0] jump_target_PC,
    output logic [31:0] PC_Dec,
    output logic [31:0] instruction_Dec,
    output logic        valid_Dec,
    output logic        pred_taken_Dec,
    output logic [31:0] redirect_count
);

    logic [31:0] pc_q;
    ifid_t       ifid_q;
    logic [31:0] count_q;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        unused_tgt_lsbs;

    assign unused_tgt_lsbs = ^jump_target_PC[1:0];

    fetch_predecode #(
        .PREDICT_EN (PREDICT_EN)
    ) u_predecode (
        .instr       (imem_rdata),
        .pc          (pc_q),
        .pred_taken  (pred_taken),
        .pred_target (pred_target)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            ifid_q  <= '{pc: RESET_PC, instr: NOP_INSTR, valid: 1'b0, pred_taken: 1'b0};
            count_q <= '0;
        end else if (npc_control) begin
            // redirect wins over stall; PC_Dec keeps its old value under the bubble
            pc_q              <= {jump_target_PC[31:2], 2'b00};
            ifid_q.instr      <= NOP_INSTR;
            ifid_q.valid      <= 1'b0;
            ifid_q.pred_taken <= 1'b0;
            if (count_q != '1) begin
                count_q <= count_q + 32'd1;
            end
        end else if (!stall) begin
            pc_q   <= pred_target;
            ifid_q <= '{pc: pc_q, instr: imem_rdata, valid: 1'b1, pred_taken: pred_taken};
        end
    end

    assign imem_addr       = pc_q;
    assign PC_Dec          = ifid_q.pc;
    assign instruction_Dec = ifid_q.instr;
    assign valid_Dec       = ifid_q.valid;
    assign pred_taken_Dec  = ifid_q.pred_taken;
    assign redirect_count  = count_q;

endmodule
